// File: rtl/spi_px_master.sv
// SPI mode-0 pixel initiator: one PX_BITS-wide full-duplex MSB-first transfer per CS frame.
// Define SPI_PX_MASTER_BURST_EN to chain pixels into a single CS frame while the source keeps up.
module spi_px_master #(
   parameter int PX_BITS = 24,
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [PX_BITS-1:0] tx_px_i,
   input  logic               tx_valid_i,
   output logic               tx_ready_o,
   output logic [PX_BITS-1:0] rx_px_o,
   output logic               rx_valid_o,
   output logic               busy_o,
   output logic               spi_sck_o,
   output logic               spi_cs_o,
   output logic               spi_sdo_o,
   input  logic               spi_sdi_i
);

   localparam int GAP_CYC = CS_GAP * CLK_DIV;
   localparam int CNT_W   = $clog2(GAP_CYC + 1);
   localparam int BIT_W   = $clog2(PX_BITS);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCK_HI,
      SCK_LO,
      GAP
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [PX_BITS-2:0] tx_sreg;
   logic [PX_BITS-1:0] rx_sreg;
   logic               last_bit;
   logic               ready_en;
   logic               ready;
   logic               accept;
   logic               half_done;
   logic               gap_done;

   assign half_done  = (cnt == CNT_W'(CLK_DIV - 1));
   assign gap_done   = (cnt == CNT_W'(GAP_CYC - 1));
   assign accept     = tx_valid_i && ready;
   assign tx_ready_o = ready;
   assign busy_o     = (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ready_en keeps tx_ready_o low for the first cycle after reset releases
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      case (state)
         IDLE: begin
            ready = ready_en;
            if (tx_valid_i && ready_en) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (half_done) begin
               state_next = SCK_HI;
            end
         end
         SCK_HI: begin
            if (half_done) begin
               state_next = SCK_LO;
            end
         end
         SCK_LO: begin
            if (half_done) begin
               if (!last_bit) begin
                  state_next = SCK_HI;
               end else begin
`ifdef SPI_PX_MASTER_BURST_EN
                  ready      = 1'b1;
                  state_next = tx_valid_i ? SCK_HI : GAP;
`else
                  state_next = GAP;
`endif
               end
            end
         end
         GAP: begin
            if (gap_done) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // SPI pins and shift registers change only on half-period boundaries;
   // MISO is sampled on the same edge that raises SCK
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt        <= '0;
         bit_cnt    <= '0;
         tx_sreg    <= '0;
         rx_sreg    <= '0;
         last_bit   <= 1'b0;
         ready_en   <= 1'b0;
         spi_sck_o  <= 1'b0;
         spi_cs_o   <= 1'b1;
         spi_sdo_o  <= 1'b0;
         rx_px_o    <= '0;
         rx_valid_o <= 1'b0;
      end else begin
         ready_en   <= 1'b1;
         rx_valid_o <= 1'b0;
         cnt        <= ((state_next != state) || (state == IDLE)) ? '0 : cnt + 1'b1;

         if (accept) begin
            tx_sreg   <= tx_px_i[PX_BITS-2:0];
            spi_sdo_o <= tx_px_i[PX_BITS-1];
            bit_cnt   <= BIT_W'(PX_BITS - 1);
            last_bit  <= 1'b0;
            spi_cs_o  <= 1'b0;
         end

         case (state)
            SETUP: begin
               if (half_done) begin
                  spi_sck_o <= 1'b1;
                  rx_sreg   <= {rx_sreg[PX_BITS-2:0], spi_sdi_i};
               end
            end
            SCK_HI: begin
               if (half_done) begin
                  spi_sck_o <= 1'b0;
                  if (bit_cnt != '0) begin
                     spi_sdo_o <= tx_sreg[PX_BITS-2];
                     tx_sreg   <= tx_sreg << 1;
                     bit_cnt   <= bit_cnt - 1'b1;
                  end else begin
                     last_bit <= 1'b1;
                  end
               end
            end
            SCK_LO: begin
               if (half_done) begin
                  if (state_next == SCK_HI) begin
                     spi_sck_o <= 1'b1;
                     rx_sreg   <= {rx_sreg[PX_BITS-2:0], spi_sdi_i};
                  end
                  // the final low half doubles as CS hold; the frame completes here
                  if (last_bit) begin
                     rx_px_o    <= rx_sreg;
                     rx_valid_o <= 1'b1;
                  end
                  if (state_next == GAP) begin
                     spi_cs_o  <= 1'b1;
                     spi_sdo_o <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
